// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and constants for the ADC capture controller: FSM state encoding,
// sample/word widths and the default output buffer depth.
package adc_capture_ctrl_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int WORD_W         = 32;
  localparam int FRAME_LEN_W    = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // FIFO entries carry the frame-end tag above the data word.
  function automatic logic [WORD_W:0] fifo_entry(input logic last, input logic [WORD_W-1:0] word);
    return {last, word};
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Output word stream towards the DMA: valid/ready handshake with a frame-end tag.
interface adc_capture_ctrl_if;
  import adc_capture_ctrl_pkg::*;

  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/adc_capture_ctrl_capture_fifo.sv
// Synchronous FIFO for captured words; a push while full is refused even if a pop
// happens on the same edge. Read data reads as zero while empty.
module capture_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Frame capture controller: enables the ADC emulator, packs samples into 32-bit
// words and buffers them for DMA. Define CAPTURE_PACK2_EN for two samples per word.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FRAME_LEN_W-1:0] frame_len,
  output logic                   adc_valid,
  input  logic [DATA_W-1:0]      adc_data,
  adc_capture_ctrl_if.master     m_if,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_adc_valid;
  logic                   r_adc_valid_d1;
  logic [FRAME_LEN_W-1:0] r_frame_len;
  logic [FRAME_LEN_W-1:0] r_word_cnt;
  logic                   r_overflow;

  logic                   w_start_ok;
  logic                   w_capture;
  logic                   w_word_done;
  logic                   w_flush;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_last_word;
  logic [FRAME_LEN_W-1:0] w_cnt_nxt;
  logic [WORD_W-1:0]      w_word;
  logic [WORD_W:0]        w_fifo_dout;

  assign w_start_ok  = (r_state == ST_IDLE) && start && (frame_len != '0);
  // The emulator answers one cycle after enable; stop suppresses that edge's sample.
  assign w_capture   = (r_state == ST_RUN) && r_adc_valid_d1 && !stop;
  assign w_cnt_nxt   = r_word_cnt + 1'b1;

`ifdef CAPTURE_PACK2_EN
  logic              r_half_vld;
  logic [DATA_W-1:0] r_half;

  assign w_flush     = (r_state == ST_RUN) && stop && r_half_vld;
  assign w_word_done = w_capture && r_half_vld;
  assign w_word      = w_flush ? WORD_W'(r_half) : WORD_W'({adc_data, r_half});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_half_vld <= 1'b0;
    else if (w_start_ok || w_flush) r_half_vld <= 1'b0;
    else if (w_capture)             r_half_vld <= !r_half_vld;
  end

  always_ff @(posedge clk) begin
    if (w_capture && !r_half_vld) r_half <= adc_data;
  end
`else
  assign w_flush     = 1'b0;
  assign w_word_done = w_capture;
  assign w_word      = WORD_W'(adc_data);
`endif

  assign w_last_word = w_flush || (w_word_done && (w_cnt_nxt == r_frame_len));
  assign w_push      = w_word_done || w_flush;
  assign w_pop       = !w_empty && m_if.m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:   if (stop || (w_word_done && (w_cnt_nxt == r_frame_len))) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (r_state != ST_IDLE) busy = 1'b1;
    if (r_state == ST_DONE) done = 1'b1;
  end

  // Dropped words still advance the count so the frame ends on time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_adc_valid    <= 1'b0;
      r_adc_valid_d1 <= 1'b0;
      r_frame_len    <= '0;
      r_word_cnt     <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_adc_valid    <= (w_state_nxt == ST_RUN);
      r_adc_valid_d1 <= r_adc_valid;
      if (w_start_ok) begin
        r_frame_len <= frame_len;
        r_word_cnt  <= '0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_word_done)     r_word_cnt <= w_cnt_nxt;
        if (w_push && w_full) r_overflow <= 1'b1;
      end
    end
  end

  capture_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_capture_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (fifo_entry(w_last_word, w_word)),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign adc_valid      = r_adc_valid;
  assign overflow       = r_overflow;
  assign m_if.m_valid   = !w_empty;
  assign m_if.m_data    = w_fifo_dout[WORD_W-1:0];
  assign m_if.m_last    = w_fifo_dout[WORD_W];

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl with a counting ADC emulator and an output-word scoreboard.
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] frame_len;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic        busy;
  logic        done;
  logic        overflow;

  adc_capture_ctrl_if m_if ();

  adc_capture_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .frame_len (frame_len),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .m_if      (m_if),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Emulator: held at zero while disabled, counts 1,2,3... once enabled.
  always @(posedge clk) begin
    if (!adc_valid) adc_data <= '0;
    else            adc_data <= adc_data + 16'd1;
  end

  typedef struct {
    int len;
    int stop_after;
    bit hold;
    bit stop_with_start;
    bit extra_start;
    int exp_nwords;
    bit exp_ovf;
    int exp_av;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          av_total = 0;
  logic        last_mvalid = 1'b0;
  logic [32:0] exp_q [$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [32:0] model_word(input int i, input int len, input int stop_after);
    logic [31:0] d;
    logic        l;
`ifdef CAPTURE_PACK2_EN
    d = {16'(2*i+2), 16'(2*i+1)};
    l = (stop_after == 0) && (i + 1 == len);
    if (stop_after != 0 && (2*i+2) > stop_after) begin
      d = 32'(2*i+1);
      l = 1'b1;
    end
`else
    d = 32'(i + 1);
    l = (stop_after == 0) && (i + 1 == len);
`endif
    return {l, d};
  endfunction

  // One cycle: score the transfer the coming edge performs, then advance.
  task automatic tick();
    logic [32:0] e;
    last_mvalid = m_if.m_valid;
    if (adc_valid) av_total++;
    if (m_if.m_valid && m_if.m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got data 0x%0h last %0b, expected no word", m_if.m_data, m_if.m_last);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 64'(m_if.m_data), 64'(e[31:0]));
        chk("word_last", 64'(m_if.m_last), 64'(e[32]));
      end
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int          n;
    int          av_base;
    logic [31:0] held;
    for (int i = 0; i < v.exp_nwords; i++) exp_q.push_back(model_word(i, v.len, v.stop_after));
    m_if.m_ready = !v.hold;
    av_base      = av_total;
    start        = 1'b1;
    frame_len    = 16'(v.len);
    stop         = v.stop_with_start;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (v.extra_start) begin
      start     = 1'b1;
      frame_len = 16'd2;
      tick();
      start = 1'b0;
      chk("busy_after_ignored_start", 64'(busy), 64'd1);
    end
    if (v.stop_after != 0) begin
      n = 0;
      while (adc_data != 16'(v.stop_after + 1) && n < 200) begin tick(); n++; end
      chk("stop_point_reached", 64'(adc_data), 64'(v.stop_after + 1));
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    if (v.hold) begin
      n = 0;
      while (adc_valid && n < 300) begin tick(); n++; end
      chk("capture_ended", 64'(adc_valid), 64'd0);
      repeat (3) tick();
      chk("hold_overflow", 64'(overflow), 64'd1);
      chk("hold_valid", 64'(m_if.m_valid), 64'd1);
      chk("hold_head", 64'(m_if.m_data), 64'(exp_q[0][31:0]));
      held = m_if.m_data;
      repeat (2) tick();
      chk("hold_stable", 64'(m_if.m_data), 64'(held));
      chk("hold_busy", 64'(busy), 64'd1);
      m_if.m_ready = 1'b1;
    end
    n = 0;
    while (!done && n < 300) begin tick(); n++; end
    chk("done_seen", 64'(done), 64'd1);
    chk("empty_before_done", 64'(last_mvalid), 64'd0);
    chk("overflow_at_done", 64'(overflow), 64'(v.exp_ovf));
    chk("words_outstanding", 64'(exp_q.size()), 64'd0);
    chk("adc_valid_cycles", 64'(av_total - av_base), 64'(v.exp_av));
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  vec_t vecs [5];

  initial begin
`ifdef CAPTURE_PACK2_EN
    vecs[0] = '{len: 4,  stop_after: 0, hold: 0, stop_with_start: 0, extra_start: 0, exp_nwords: 4, exp_ovf: 0, exp_av: 9};
    vecs[1] = '{len: 10, stop_after: 3, hold: 0, stop_with_start: 0, extra_start: 0, exp_nwords: 2, exp_ovf: 0, exp_av: 5};
    vecs[2] = '{len: 1,  stop_after: 0, hold: 0, stop_with_start: 1, extra_start: 0, exp_nwords: 1, exp_ovf: 0, exp_av: 3};
    vecs[3] = '{len: 5,  stop_after: 4, hold: 0, stop_with_start: 0, extra_start: 1, exp_nwords: 2, exp_ovf: 0, exp_av: 6};
    vecs[4] = '{len: 8,  stop_after: 0, hold: 1, stop_with_start: 0, extra_start: 0, exp_nwords: 4, exp_ovf: 1, exp_av: 17};
`else
    vecs[0] = '{len: 3, stop_after: 0, hold: 0, stop_with_start: 0, extra_start: 0, exp_nwords: 3, exp_ovf: 0, exp_av: 4};
    vecs[1] = '{len: 1, stop_after: 0, hold: 0, stop_with_start: 1, extra_start: 0, exp_nwords: 1, exp_ovf: 0, exp_av: 2};
    vecs[2] = '{len: 5, stop_after: 2, hold: 0, stop_with_start: 0, extra_start: 1, exp_nwords: 2, exp_ovf: 0, exp_av: 4};
    vecs[3] = '{len: 6, stop_after: 0, hold: 0, stop_with_start: 0, extra_start: 0, exp_nwords: 6, exp_ovf: 0, exp_av: 7};
    vecs[4] = '{len: 8, stop_after: 0, hold: 1, stop_with_start: 0, extra_start: 0, exp_nwords: 4, exp_ovf: 1, exp_av: 9};
`endif

    reset        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    frame_len    = '0;
    m_if.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_adc_valid", 64'(adc_valid), 64'd0);
    chk("rst_m_valid",   64'(m_if.m_valid), 64'd0);
    chk("rst_m_last",    64'(m_if.m_last), 64'd0);
    chk("rst_m_data",    64'(m_if.m_data), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_done",      64'(done), 64'd0);
    chk("rst_overflow",  64'(overflow), 64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Zero-length start and a lone stop must leave the controller idle.
    start     = 1'b1;
    frame_len = 16'd0;
    tick();
    start = 1'b0;
    chk("zero_len_busy", 64'(busy), 64'd0);
    chk("zero_len_adc_valid", 64'(adc_valid), 64'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_busy", 64'(busy), 64'd0);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Reset in the middle of a running frame.
    for (int i = 0; i < 8; i++) exp_q.push_back(model_word(i, 8, 0));
    start     = 1'b1;
    frame_len = 16'd8;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_adc_valid", 64'(adc_valid), 64'd0);
    chk("mid_rst_m_valid",   64'(m_if.m_valid), 64'd0);
    chk("mid_rst_m_data",    64'(m_if.m_data), 64'd0);
    chk("mid_rst_m_last",    64'(m_if.m_last), 64'd0);
    chk("mid_rst_busy",      64'(busy), 64'd0);
    chk("mid_rst_done",      64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_done", 64'(done), 64'd0);
    end
    chk("post_rst_idle", 64'(busy), 64'd0);
    run_vec('{len: 2, stop_after: 0, hold: 0, stop_with_start: 0, extra_start: 0,
              exp_nwords: 2, exp_ovf: 0,
`ifdef CAPTURE_PACK2_EN
              exp_av: 5});
`else
              exp_av: 3});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, sample width from the ADC emulator link.
REQ-002 Parameter: FIFO_DEPTH, 4, output word buffer depth (power of 2, >=2).
REQ-003 Port: clk  in  1  single clock; all logic on posedge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  one-cycle request to begin a frame.
REQ-006 Port: stop  in  1  one-cycle request to end a frame early.
REQ-007 Port: frame_len  in  16  words per frame; sampled on accepted start.
REQ-008 Port: adc_valid  out  1  drives emulator valid (enable; low holds emulator in reset).
REQ-009 Port: adc_data  in  DATA_W  emulator link sample.
REQ-010 Port: m_data  out  32  output word to DMA.
REQ-011 Port: m_valid  out  1  output word present.
REQ-012 Port: m_ready  in  1  DMA accepts word when m_valid&m_ready.
REQ-013 Port: m_last  out  1  marks final word of frame; qualified by m_valid.
REQ-014 Port: busy  out  1  high in any state except IDLE.
REQ-015 Port: done  out  1  one-cycle pulse at frame completion.
REQ-016 Port: overflow  out  1  sticky: a word was dropped this frame.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; registered state.
REQ-018 IDLE: start with frame_len!=0 -> RUN; latch frame_len, clear counters, clear overflow; start with frame_len==0 ignored.
REQ-019 start and stop in same cycle in IDLE: start wins; stop ignored outside RUN; start ignored outside IDLE.
REQ-020 adc_valid registered, high exactly while state==RUN.
REQ-021 Sample captured on each edge where adc_valid was high at the previous edge (1-cycle emulator latency); first captured sample of a frame is the emulator's first post-enable value.
REQ-022 Word count increments per completed word; word equal to latched frame_len is tagged last, enqueued, and state -> DRAIN same edge.
REQ-023 stop in RUN -> DRAIN next edge; pending partial word (packing mode) enqueued zero-padded in upper half with last=1; with no pending half, no extra word and no last emitted.
REQ-024 Enqueue with FIFO full: word dropped, overflow set, word count still increments (frame timing preserved).
REQ-025 FIFO pops on m_valid&m_ready; m_data/m_last stable while m_valid&!m_ready; m_valid = FIFO not empty; simultaneous push/pop when full is a drop (full checked before pop).
REQ-026 DRAIN: waits FIFO empty -> DONE; DONE lasts one cycle with done=1 -> IDLE.
REQ-027 overflow holds until next accepted start or reset.

Reset
REQ-028 Async assertion: state IDLE, FIFO empty, counters 0; adc_valid, m_valid, m_last, busy, done, overflow all 0; m_data 0.
REQ-029 Reset mid-frame aborts frame; no word or done emitted after deassertion.

Configuration
REQ-030 Macro CAPTURE_PACK2_EN defined: two samples per word, first sample in m_data[15:0], second in [31:16]; frame_len counts words (2 samples each).
REQ-031 Macro undefined: one sample per word, zero-extended to 32 bits; no partial-word logic; REQ-023 padding path absent.

Structure
REQ-032 Shared package holds FSM state enum, DATA_W/word-width constants, default FIFO_DEPTH.
REQ-033 One sub-module: capture_fifo (synchronous FIFO, 32+1 bits wide, full/empty flags).

Verification
REQ-034 PACK on, frame_len=4, m_ready=1, real emulator: words 0x00020001, 0x00040003, 0x00060005, 0x00080007, last on 4th, done 1 cycle after FIFO empty, overflow=0.
REQ-035 PACK off, frame_len=3: words 1, 2, 3; last on word 3; adc_valid high exactly 4 cycles.
REQ-036 m_ready=0, frame_len=8, PACK off: first 4 words held, words 5-8 dropped, overflow=1; release m_ready -> 4 words out, none tagged last, done pulses.
REQ-037 PACK on, frame_len=10, stop after 3 samples captured: words 0x00020001, 0x00000003 (last); done pulses.
REQ-038 Reset asserted in RUN: all outputs 0 immediately; start after release begins fresh frame with first sample 1.
REQ-039 start with frame_len=0 and start while busy: no state change, busy unchanged.
